// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified memory port arbiter.
// Optional round-robin arbitration is enabled with MEM_ARB_RR_EN.
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_e;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_e;
endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and data requests.
// MEM_ARB_RR_EN selects round-robin on last owner; otherwise data wins ties.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_if_req,
  input  logic   i_d_req,
`ifdef MEM_ARB_RR_EN
  input  owner_e i_last,
`endif
  output logic   o_valid,
  output owner_e o_win
);
  always_comb begin
    o_valid = i_if_req | i_d_req;
    o_win   = OWN_DATA;
`ifdef MEM_ARB_RR_EN
    // On a tie, serve whoever was not served last.
    if (i_if_req && (!i_d_req || i_last == OWN_DATA)) o_win = OWN_FETCH;
`else
    if (i_if_req && !i_d_req) o_win = OWN_FETCH;
`endif
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// IDLE/RESP arbitrate, ACCESS drives the memory for one cycle. MEM_ARB_RR_EN enables round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  state_e            r_state, w_next;
  owner_e            r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, r_if_rdata, r_d_rdata;
  logic              w_valid, w_launch, w_acc, w_resp;
  owner_e            w_win;
  logic              w_unused_lo;

  assign w_unused_lo = ^{if_addr[1:0], d_addr[1:0]};

`ifdef MEM_ARB_RR_EN
  owner_e r_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_last <= OWN_FETCH;
    else if (w_launch) r_last <= w_win;
  end

  mem_arb_pick u_pick (
    .i_if_req (if_req),
    .i_d_req  (d_req),
    .i_last   (r_last),
    .o_valid  (w_valid),
    .o_win    (w_win)
  );
`else
  mem_arb_pick u_pick (
    .i_if_req (if_req),
    .i_d_req  (d_req),
    .o_valid  (w_valid),
    .o_win    (w_win)
  );
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_RESP: w_next = w_valid ? ST_ACCESS : ST_IDLE;
      ST_ACCESS:        w_next = ST_RESP;
      default:          w_next = ST_IDLE;
    endcase
  end

  assign w_acc    = (r_state == ST_ACCESS);
  assign w_resp   = (r_state == ST_RESP);
  assign w_launch = w_valid && (r_state != ST_ACCESS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner     <= OWN_DATA;
      r_we        <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      if (w_launch) begin
        r_owner <= w_win;
        if (w_win == OWN_DATA) begin
          r_we        <= d_we;
          r_mem_addr  <= {d_addr[ADDR_W-1:2], 2'b00};
          r_mem_wdata <= d_wdata;
        end else begin
          r_we       <= 1'b0;
          r_mem_addr <= {if_addr[ADDR_W-1:2], 2'b00};
        end
      end
      // Memory read data is combinational; capture it at the end of ACCESS.
      if (w_acc && !r_we) begin
        if (r_owner == OWN_FETCH) r_if_rdata <= mem_rdata;
        else                      r_d_rdata  <= mem_rdata;
      end
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_read  = w_acc & ~r_we;
  assign mem_write = w_acc &  r_we;
  assign if_gnt    = w_acc & (r_owner == OWN_FETCH);
  assign d_gnt     = w_acc & (r_owner == OWN_DATA);
  assign if_rvalid = w_resp & ~r_we & (r_owner == OWN_FETCH);
  assign d_rvalid  = w_resp & ~r_we & (r_owner == OWN_DATA);
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign busy      = w_acc | w_resp;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small word memory model.
// Honours MEM_ARB_RR_EN for the arbitration-order expectations.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_read, mem_write, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [0:63];
  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[3] = 32'h1000FFFF;
    reset = 1'b0; if_req = 0; d_req = 0; d_we = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0;
    #1;
    chk("reset_outs", {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_read, mem_write, busy}, 0);
    chk("reset_data", {mem_addr, mem_wdata}, 0);
    chk("reset_rdata", {if_rdata, d_rdata}, 0);
    tick; tick;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("idle_outs", {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_read, mem_write, busy}, 0);
    end

    // Fetch read of word 3
    if_req = 1; if_addr = 32'h0000000C;
    tick;
    chk("f_gnt", {if_gnt, d_gnt}, 2'b10);
    chk("f_addr", mem_addr, 32'h0C);
    chk("f_strobe", {mem_read, mem_write, busy}, 3'b101);
    if_req = 0;
    tick;
    chk("f_rvalid", {if_rvalid, d_rvalid, mem_read, busy}, 4'b1001);
    chk("f_rdata", if_rdata, 32'h1000FFFF);
    tick;
    chk("f_idle", {if_rvalid, busy}, 0);
    chk("f_hold", if_rdata, 32'h1000FFFF);

    // Store then load
    d_req = 1; d_we = 1; d_addr = 32'h84; d_wdata = 32'hDEADBEEF;
    tick;
    chk("st_gnt", {if_gnt, d_gnt}, 2'b01);
    chk("st_strobe", {mem_read, mem_write}, 2'b01);
    chk("st_bus", {mem_addr, mem_wdata}, {32'h84, 32'hDEADBEEF});
    d_req = 0; d_we = 0;
    tick;
    chk("st_norvalid", {d_rvalid, mem_write, busy}, 3'b001);
    tick;
    d_req = 1; d_addr = 32'h84;
    tick;
    chk("ld_gnt", {d_gnt, mem_read, mem_write}, 3'b110);
    d_req = 0;
    tick;
    chk("ld_rvalid", {d_rvalid, if_rvalid}, 2'b10);
    chk("ld_rdata", d_rdata, 32'hDEADBEEF);
    tick;
    chk("ld_once", d_rvalid, 0);

    // Misaligned load
    d_req = 1; d_addr = 32'h87;
    tick;
    chk("mis_addr", mem_addr, 32'h84);
    d_req = 0;
    tick;
    chk("mis_rdata", {d_rvalid, d_rdata}, {1'b1, 32'hDEADBEEF});
    tick;

    // Fetch-only access leaves last owner = fetch
    if_req = 1; if_addr = 32'h0C;
    tick; if_req = 0;
    tick; tick;

    // Collision: data first, fetch granted in cycle 3
    if_req = 1; if_addr = 32'h0C; d_req = 1; d_we = 0; d_addr = 32'h84;
    tick;
    chk("col_c1", {if_gnt, d_gnt}, 2'b01);
    d_req = 0;
    tick;
    chk("col_c2", {d_rvalid, if_gnt}, 2'b10);
    tick;
    chk("col_c3", {if_gnt, d_gnt, mem_addr}, {2'b10, 32'h0C});
    if_req = 0;
    tick;
    chk("col_c4", {if_rvalid, if_rdata}, {1'b1, 32'h1000FFFF});
    tick;

    // Repeated collisions with both requests held
    if_req = 1; d_req = 1;
    tick;
    chk("rep_1", {if_gnt, d_gnt}, 2'b01);
    tick; tick;
`ifdef MEM_ARB_RR_EN
    chk("rep_2", {if_gnt, d_gnt}, 2'b10);
`else
    chk("rep_2", {if_gnt, d_gnt}, 2'b01);
`endif
    tick; tick;
    chk("rep_3", {if_gnt, d_gnt}, 2'b01);
    if_req = 0; d_req = 0;
    tick; tick;
    chk("rep_idle", busy, 0);

    // Reset during ACCESS of a store
    d_req = 1; d_we = 1; d_addr = 32'h90; d_wdata = 32'h12345678;
    tick;
    chk("rst_pre", mem_write, 1);
    d_req = 0; d_we = 0;
    #1 reset = 1'b0;
    #1;
    chk("rst_drop", {mem_write, mem_read, d_gnt, busy}, 0);
    tick;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rst_after", {if_gnt, d_gnt, if_rvalid, d_rvalid, busy}, 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
